// File: rtl/reg_file_loader_if.sv
// ----------------------------------------------------------------------------
// reg_file_loader_if
//   Groups the byte-stream handshake and the register-file write port used by
//   reg_file_loader.
//   Signals:
//     in_data  [7:0]  stream byte
//     in_valid        in_data is valid
//     in_ready        loader accepts a byte (transfer = in_valid & in_ready)
//     wa       [4:0]  register write address
//     wd       [31:0] register write data
//     we              register write enable
//   Modports:
//     slave  - the loader: consumes the stream, drives the write port
//     master - the environment: produces the stream, observes the write port
// ----------------------------------------------------------------------------
interface reg_file_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        we;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output wa,
    output wd,
    output we
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  wa,
    input  wd,
    input  we
  );
endinterface

// File: rtl/reg_file_loader.sv
// ----------------------------------------------------------------------------
// reg_file_loader
//   Streams initial register contents into a register file through its write
//   port. Bytes arrive on a valid/ready stream, are packed four at a time
//   little-endian into a 32-bit word, and each word is written to registers
//   FIRST_REG..LAST_REG in ascending order (x0 is never written).
//   Ports:
//     clk    in   clock, all state on rising edge
//     rst_n  in   asynchronous reset, active low
//     start  in   begin a load (only honoured in IDLE)
//     abort  in   cancel a load, return to IDLE
//     busy   out  high in any state other than IDLE
//     done   out  one-cycle pulse after the last register is written
//     bus    slave modport: in_data/in_valid/in_ready stream and wa/wd/we
//   Every output decodes from registered state only.
// ----------------------------------------------------------------------------
module reg_file_loader #(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  reg_file_loader_if.slave   bus
);

  localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
  localparam logic [4:0] LAST_A  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic [4:0]  wa_q, wa_d;
  logic [31:0] wd_q, wd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= 2'd0;
      addr_q     <= 5'd0;
      word_q     <= 32'd0;
      wa_q       <= 5'd0;
      wd_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    word_d     = word_q;
    wa_d       = wa_q;
    wd_d       = wd_q;

    case (state_q)
      IDLE: begin
        // abort has priority over start when both are raised together
        if (start && !abort) begin
          state_d    = COLLECT;
          addr_d     = FIRST_A;
          byte_cnt_d = 2'd0;
          word_d     = 32'd0;
        end
      end

      COLLECT: begin
        if (abort) begin
          // a partially assembled word is thrown away
          state_d    = IDLE;
          byte_cnt_d = 2'd0;
          word_d     = 32'd0;
        end else if (bus.in_valid) begin
          // in_ready is high throughout COLLECT, so in_valid alone is a transfer
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: word_d[7:0]   = bus.in_data;
            2'd1: word_d[15:8]  = bus.in_data;
            2'd2: word_d[23:16] = bus.in_data;
            2'd3: begin
              // Load the write port registers now so wa/wd are valid for
              // the single WRITE cycle and then hold their last value.
              state_d    = WRITE;
              byte_cnt_d = 2'd0;
              word_d     = 32'd0;
              wa_d       = addr_q;
              wd_d       = {bus.in_data, word_q[23:0]};
            end
          endcase
        end
      end

      WRITE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (addr_q == LAST_A) begin
          state_d = DONE;
        end else begin
          state_d = COLLECT;
          addr_d  = addr_q + 5'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready = (state_q == COLLECT);
  assign bus.we       = (state_q == WRITE);
  assign bus.wa       = wa_q;
  assign bus.wd       = wd_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_reg_file_loader.sv
// ----------------------------------------------------------------------------
// tb_reg_file_loader
//   Self-checking bench for reg_file_loader. A default instance (r1..r31) and
//   a single-register instance (r7 only) share clock and reset. Expected
//   register writes are queued when the 4th byte of a word is driven and are
//   popped by a monitor whenever the write enable is seen.
// ----------------------------------------------------------------------------
module tb_reg_file_loader;

  logic clk = 1'b0;
  logic rst_n;
  logic start, abort, busy, done;
  logic start7, abort7, busy7, done7;

  reg_file_loader_if bus ();
  reg_file_loader_if b7 ();

  reg_file_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .bus   (bus.slave)
  );

  reg_file_loader #(.FIRST_REG(7), .LAST_REG(7)) dut7 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start7),
    .abort (abort7),
    .busy  (busy7),
    .done  (done7),
    .bus   (b7.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } exp_t;
  exp_t exp_q[$];

  int we_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int prev_we_cyc = 0;
  bit have_prev = 1'b0;
  bit chk_spacing = 1'b0;
  int we7_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the default instance
  always @(negedge clk) begin
    if (rst_n && bus.we) begin
      exp_t e;
      we_cnt++;
      nvec++;
      if (exp_q.size() == 0) begin
        nmis++;
        $display("FAIL unexpected_write: got wa=%0d wd=0x%0h, want no write", bus.wa, bus.wd);
      end else begin
        e = exp_q.pop_front();
        if (bus.wa !== e.wa || bus.wd !== e.wd) begin
          nmis++;
          $display("FAIL write: got wa=%0d wd=0x%0h, want wa=%0d wd=0x%0h",
                   bus.wa, bus.wd, e.wa, e.wd);
        end
      end
      if (chk_spacing && have_prev) begin
        nvec++;
        if (cyc - prev_we_cyc != 5) begin
          nmis++;
          $display("FAIL we_spacing: got %0d cycles, want 5", cyc - prev_we_cyc);
        end
      end
      prev_we_cyc = cyc;
      have_prev   = 1'b1;
    end
    if (rst_n && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rst_n && b7.we) we7_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    int g;
    g = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      g++;
      if (g > 100) break;
    end
    if (g > 100) begin
      nvec++;
      nmis++;
      $display("FAIL in_ready_timeout: got in_ready=0, want 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [4:0] a, input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    exp_q.push_back('{wa: a, wd: w});
    send_byte(w[31:24]);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          g0, g1, g2, g3;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int w0, d0, g;

    vecs[0] = '{b0: 8'h78, b1: 8'h56, b2: 8'h34, b3: 8'h12, g0: 0, g1: 2, g2: 1, g3: 3, wd: 32'h12345678};
    vecs[1] = '{b0: 8'h00, b1: 8'h00, b2: 8'h00, b3: 8'h00, g0: 1, g1: 0, g2: 0, g3: 0, wd: 32'h00000000};
    vecs[2] = '{b0: 8'hFF, b1: 8'hFF, b2: 8'hFF, b3: 8'hFF, g0: 0, g1: 0, g2: 0, g3: 0, wd: 32'hFFFFFFFF};
    vecs[3] = '{b0: 8'h01, b1: 8'h02, b2: 8'h03, b3: 8'h80, g0: 3, g1: 3, g2: 3, g3: 3, wd: 32'h80030201};
    vecs[4] = '{b0: 8'hEF, b1: 8'hBE, b2: 8'hAD, b3: 8'hDE, g0: 2, g1: 0, g2: 4, g3: 1, wd: 32'hDEADBEEF};

    rst_n = 1'b1;
    start = 1'b0; abort = 1'b0;
    start7 = 1'b0; abort7 = 1'b0;
    bus.in_data = 8'h00; bus.in_valid = 1'b0;
    b7.in_data = 8'h00; b7.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #2;

    // Reset state
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_we",       64'(bus.we),       64'd0);
    chk("rst_busy",     64'(busy),         64'd0);
    chk("rst_done",     64'(done),         64'd0);
    chk("rst_wa",       64'(bus.wa),       64'd0);
    chk("rst_wd",       64'(bus.wd),       64'd0);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(1);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy",     64'(busy),         64'd0);
    chk("start_abort_in_ready", 64'(bus.in_ready), 64'd0);

    // Table-driven single words with backpressure gaps, aborted after r1
    for (int i = 0; i < 5; i++) begin
      do_start();
      idle_cycles(vecs[i].g0);
      send_byte(vecs[i].b0);
      idle_cycles(vecs[i].g1);
      send_byte(vecs[i].b1);
      idle_cycles(vecs[i].g2);
      send_byte(vecs[i].b2);
      idle_cycles(vecs[i].g3);
      exp_q.push_back('{wa: 5'd1, wd: vecs[i].wd});
      send_byte(vecs[i].b3);
      drain("vec_drain");
      do_abort();
      chk("vec_abort_busy", 64'(busy), 64'd0);
    end

    // Full load r1..r31 with in_valid held
    w0 = we_cnt;
    d0 = done_cnt;
    have_prev = 1'b0;
    chk_spacing = 1'b1;
    do_start();
    for (int r = 1; r <= 31; r++) send_word(5'(r), 32'hA5000000 | 32'(r));
    g = 0;
    while (done_cnt == d0 && g < 20) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk_spacing = 1'b0;
    chk("full_done_cnt",   64'(done_cnt - d0),       64'd1);
    chk("full_done_delay", 64'(done_cyc - prev_we_cyc), 64'd1);
    chk("full_we_cnt",     64'(we_cnt - w0),          64'd31);
    chk("full_queue",      64'(exp_q.size()),         64'd0);
    @(posedge clk);
    #1;
    chk("full_busy_after", 64'(busy), 64'd0);
    chk("full_done_after", 64'(done), 64'd0);

    // Abort mid-word in r5, then restart with fresh alignment
    do_start();
    for (int r = 1; r <= 4; r++) send_word(5'(r), 32'h5A000000 | 32'(r << 8));
    send_byte(8'hC1);
    send_byte(8'hC2);
    d0 = done_cnt;
    do_abort();
    chk("abort_busy",     64'(busy),         64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
    idle_cycles(4);
    chk("abort_no_done",  64'(done_cnt - d0), 64'd0);
    chk("abort_queue",    64'(exp_q.size()),  64'd0);
    do_start();
    send_word(5'd1, 32'h11223344);
    drain("restart_drain");
    do_abort();

    // Reset during the WRITE of r10
    do_start();
    for (int r = 1; r <= 10; r++) send_word(5'(r), 32'h0F000000 | 32'(r << 16));
    chk("r10_we_high", 64'(bus.we), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we",       64'(bus.we),       64'd0);
    chk("mid_rst_wa",       64'(bus.wa),       64'd0);
    chk("mid_rst_wd",       64'(bus.wd),       64'd0);
    chk("mid_rst_busy",     64'(busy),         64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_pending",  64'(exp_q.size()), 64'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    w0 = we_cnt;
    bus.in_data = 8'h99;
    bus.in_valid = 1'b1;
    idle_cycles(10);
    bus.in_valid = 1'b0;
    chk("post_rst_no_we", 64'(we_cnt - w0), 64'd0);
    chk("post_rst_busy",  64'(busy),        64'd0);

    // Single-register instance: r7 only, start during load ignored
    start7 = 1'b1;
    @(posedge clk);
    #1 start7 = 1'b0;
    b7.in_valid = 1'b1;
    b7.in_data  = 8'h44;
    @(posedge clk);
    #1 b7.in_data = 8'h33; start7 = 1'b1;
    @(posedge clk);
    #1 b7.in_data = 8'h22; start7 = 1'b0;
    @(posedge clk);
    #1 b7.in_data = 8'h11;
    @(posedge clk);
    #1 b7.in_valid = 1'b0;
    chk("r7_we",   64'(b7.we), 64'd1);
    chk("r7_wa",   64'(b7.wa), 64'd7);
    chk("r7_wd",   64'(b7.wd), 64'h11223344);
    @(posedge clk);
    #1;
    chk("r7_done",     64'(done7), 64'd1);
    chk("r7_we_after", 64'(b7.we), 64'd0);
    @(posedge clk);
    #1;
    chk("r7_done_pulse", 64'(done7), 64'd0);
    chk("r7_busy_after", 64'(busy7), 64'd0);
    idle_cycles(6);
    chk("r7_we_cnt",    64'(we7_cnt), 64'd1);
    chk("r7_no_restart", 64'(busy7),  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
